// File: rtl/maxpool2d.sv
// maxpool2d: streaming 2x2 / stride-2 max-pooling stage.
//
// Takes a raster-ordered, channel-major feature-map stream (one signed Q8.8
// word per accepted in_valid, no backpressure) and emits one pooled word per
// 2x2 window together with its linear address c*OH*OW + pr*OW + pc.
//
// Optional build macro: MAXPOOL_RELU_EN -- when defined, a ReLU is fused on
// the output (negative maxima become 0). Addressing and timing are unchanged.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous, active-high
//   start      in   one-cycle pulse, begins a frame (honoured in IDLE only)
//   in_data    in   16-bit signed feature-map word
//   in_valid   in   in_data valid this cycle (accepted in RUN only)
//   out_data   out  16-bit signed pooled word (registered, held between strobes)
//   out_addr   out  linear output address (registered, held between strobes)
//   out_valid  out  one-cycle strobe for out_data/out_addr
//   pool_done  out  one-cycle pulse one cycle after the final output
//   busy       out  high while a frame is in progress
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; in_valid ignored
// RUN    | accepting inputs; leaves after the last (c,r,col) word
// FLUSH  | one cycle after the last input; pool_done follows
module maxpool2d #(
  parameter int INPUT_WIDTH  = 62,
  parameter int INPUT_HEIGHT = 62,
  parameter int NUM_CHANNELS = 30,
  localparam int OW   = INPUT_WIDTH / 2,
  localparam int OH   = INPUT_HEIGHT / 2,
  localparam int NOUT = OW * OH * NUM_CHANNELS,
  localparam int AW   = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [15:0]   in_data,
  input  logic                 in_valid,
  output logic signed [15:0]   out_data,
  output logic [AW-1:0]        out_addr,
  output logic                 out_valid,
  output logic                 pool_done,
  output logic                 busy
);

  localparam int COLW = (INPUT_WIDTH > 1)  ? $clog2(INPUT_WIDTH)  : 1;
  localparam int ROWW = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1;
  localparam int CHW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BW   = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [COLW-1:0] COL_LAST = COLW'(INPUT_WIDTH - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(INPUT_HEIGHT - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [COLW-1:0] col;
  logic [ROWW-1:0] row;
  logic [CHW-1:0]  ch;
  logic [AW-1:0]   out_cnt;

  logic signed [15:0] line_buf [OW];
  logic signed [15:0] hmax;
  logic signed [15:0] buf_rd;
  logic signed [15:0] result_raw;
  logic signed [15:0] result;
  logic [BW-1:0]      buf_idx;

  logic accept;
  logic last_in;
  logic col_in;
  logic row_in;
  logic pool_in;
  logic emit;
  logic frame_start;

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  assign frame_start = (state == S_IDLE) && start;
  assign accept      = (state == S_RUN) && in_valid;
  assign last_in     = accept && (col == COL_LAST) && (row == ROW_LAST) && (ch == CH_LAST);

  // The trailing column/row of an odd-sized map has no partner, so it is
  // consumed (counters advance) but never touches the pooling datapath.
  assign col_in  = (INPUT_WIDTH % 2 == 0)  || (col != COL_LAST);
  assign row_in  = (INPUT_HEIGHT % 2 == 0) || (row != ROW_LAST);
  assign pool_in = accept && col_in && row_in;
  assign emit    = pool_in && row[0] && col[0];

  assign buf_idx    = BW'(col >> 1);
  assign buf_rd     = line_buf[buf_idx];
  assign result_raw = smax(hmax, in_data);

`ifdef MAXPOOL_RELU_EN
  assign result = result_raw[15] ? 16'sd0 : result_raw;
`else
  assign result = result_raw;
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)   state_nxt = S_RUN;
      S_RUN:   if (last_in) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
          ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffer and horizontal register carry no reset: every read in an odd
  // row is preceded by the matching write in the even row of the same pair.
  always_ff @(posedge clk) begin
    if (pool_in) begin
      case ({row[0], col[0]})
        2'b00:   hmax <= in_data;
        2'b01:   line_buf[buf_idx] <= smax(hmax, in_data);
        2'b10:   hmax <= smax(buf_rd, in_data);
        default: ;
      endcase
    end
  end

  // Windows complete strictly in (c, pr, pc) order, so the linear output
  // address is simply the running count of emitted words.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      pool_done <= 1'b0;
      out_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      pool_done <= (state == S_FLUSH);
      if (frame_start) out_cnt <= '0;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_addr  <= out_cnt;
        out_cnt   <= out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2d.sv
// tb_maxpool2d: self-checking bench for maxpool2d.
// Instance A is a 4x4, 2-channel map; instance B is a 5x5, 1-channel map
// (odd dimensions). Expected outputs come from a window-by-window reference
// model computed directly from the full input frame.
module tb_maxpool2d;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: W=H=4, C=2
  logic               start_a, in_valid_a;
  logic signed [15:0] in_data_a, out_data_a;
  logic [2:0]         out_addr_a;
  logic               out_valid_a, pool_done_a, busy_a;

  // instance B: W=H=5, C=1
  logic               start_b, in_valid_b;
  logic signed [15:0] in_data_b, out_data_b;
  logic [1:0]         out_addr_b;
  logic               out_valid_b, pool_done_b, busy_b;

  maxpool2d #(.INPUT_WIDTH(4), .INPUT_HEIGHT(4), .NUM_CHANNELS(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_data(in_data_a),
    .in_valid(in_valid_a), .out_data(out_data_a), .out_addr(out_addr_a),
    .out_valid(out_valid_a), .pool_done(pool_done_a), .busy(busy_a)
  );

  maxpool2d #(.INPUT_WIDTH(5), .INPUT_HEIGHT(5), .NUM_CHANNELS(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_data(in_data_b),
    .in_valid(in_valid_b), .out_data(out_data_b), .out_addr(out_addr_b),
    .out_valid(out_valid_b), .pool_done(pool_done_b), .busy(busy_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic signed [31:0] qa_data[$], qa_addr[$];
  int                 qa_cyc[$];
  int                 done_a_cnt, done_a_cyc;
  logic signed [31:0] qb_data[$], qb_addr[$];
  int                 qb_cyc[$];
  int                 done_b_cnt, done_b_cyc;

  int exp_data[$], exp_addr[$];

  always @(negedge clk) begin
    if (out_valid_a) begin
      qa_data.push_back($signed(out_data_a));
      qa_addr.push_back({29'd0, out_addr_a});
      qa_cyc.push_back(cyc);
    end
    if (pool_done_a) begin
      done_a_cnt = done_a_cnt + 1;
      done_a_cyc = cyc;
    end
    if (out_valid_b) begin
      qb_data.push_back($signed(out_data_b));
      qb_addr.push_back({30'd0, out_addr_b});
      qb_cyc.push_back(cyc);
    end
    if (pool_done_b) begin
      done_b_cnt = done_b_cnt + 1;
      done_b_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: for every window take the max of its four words directly.
  task automatic model_pool(input int fr[$], input int w, input int h, input int nc);
    int ow, oh, m, v;
    ow = w / 2;
    oh = h / 2;
    exp_data.delete();
    exp_addr.delete();
    for (int c = 0; c < nc; c++)
      for (int pr = 0; pr < oh; pr++)
        for (int pc = 0; pc < ow; pc++) begin
          m = -32768;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = fr[c*h*w + (2*pr+dy)*w + 2*pc + dx];
              if (v > m) m = v;
            end
`ifdef MAXPOOL_RELU_EN
          if (m < 0) m = 0;
`endif
          exp_data.push_back(m);
          exp_addr.push_back(c*oh*ow + pr*ow + pc);
        end
  endtask

  task automatic compare_a(input string tag);
    check({tag, "_count"}, qa_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < qa_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), qa_data[i], exp_data[i]);
      check($sformatf("%s_addr%0d", tag, i), qa_addr[i], exp_addr[i]);
    end
  endtask

  task automatic clear_a();
    qa_data.delete();
    qa_addr.delete();
    qa_cyc.delete();
    done_a_cnt = 0;
    done_a_cyc = -1;
  endtask

  // Drive a start pulse then the frame words. Idle gap cycles carry random
  // data with in_valid low. mid_start >= 0 raises start alongside that word.
  task automatic feed_a(input int fr[$], input int gap_pct, input int mid_start,
                        input int stop_after, input bit start_with_valid,
                        output int last_drive_cyc);
    int n;
    n = (stop_after < 0) ? fr.size() : stop_after;
    @(posedge clk); #1;
    start_a    = 1'b1;
    in_valid_a = start_with_valid;
    in_data_a  = 16'sh7fff;
    last_drive_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(posedge clk); #1;
        start_a    = 1'b0;
        in_valid_a = 1'b0;
        in_data_a  = 16'($urandom);
      end
      @(posedge clk); #1;
      start_a    = (i == mid_start);
      in_valid_a = 1'b1;
      in_data_a  = 16'(fr[i]);
      last_drive_cyc = cyc;
    end
    @(posedge clk); #1;
    start_a    = 1'b0;
    in_valid_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n;
    n = 0;
    while (done_a_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_done_pulses"}, done_a_cnt, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fr0[$], frr[$], frb[$];
    int ld;
    logic [15:0] r;

    reset = 1'b1;
    start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
    clear_a();
    done_b_cnt = 0;
    done_b_cyc = -1;

    for (int i = 0; i < 16; i++) fr0.push_back(i);
    for (int i = 0; i < 16; i++) fr0.push_back(-i);
    for (int i = 0; i < 25; i++) frb.push_back(i);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_a_out_data",  $signed(out_data_a), 0);
    check("rst_a_out_addr",  {29'd0, out_addr_a}, 0);
    check("rst_a_out_valid", {31'd0, out_valid_a}, 0);
    check("rst_a_pool_done", {31'd0, pool_done_a}, 0);
    check("rst_a_busy",      {31'd0, busy_a}, 0);
    check("rst_b_busy",      {31'd0, busy_b}, 0);

    // gap-free 4x4 C=2 frame: ch0 = 0..15, ch1 = its negation
    clear_a();
    feed_a(fr0, 0, -1, -1, 1'b0, ld);
    check("t1_busy_flush", {31'd0, busy_a}, 1);
    wait_done_a("t1", 20);
    model_pool(fr0, 4, 4, 2);
    compare_a("t1");
    if (qa_data.size() >= 4) begin
      check("t1_ch0_first", qa_data[0], 5);
      check("t1_ch0_last",  qa_data[3], 15);
    end
    if (qa_cyc.size() > 0) begin
      check("t1_last_out_latency", qa_cyc[qa_cyc.size()-1], ld + 1);
      check("t1_done_after_last",  done_a_cyc, qa_cyc[qa_cyc.size()-1] + 1);
    end
    check("t1_busy_after_done", {31'd0, busy_a}, 0);
    check("t1_hold_addr", {29'd0, out_addr_a}, 7);

    // same frame with ~50% in_valid gaps
    clear_a();
    feed_a(fr0, 50, -1, -1, 1'b0, ld);
    wait_done_a("t2", 20);
    compare_a("t2");

    // random signed data with gaps
    for (int k = 0; k < 3; k++) begin
      frr.delete();
      for (int i = 0; i < 32; i++) begin
        r = 16'($urandom);
        frr.push_back(int'($signed(r)));
      end
      clear_a();
      feed_a(frr, 50, -1, -1, 1'b0, ld);
      wait_done_a($sformatf("t3r%0d", k), 20);
      model_pool(frr, 4, 4, 2);
      compare_a($sformatf("t3r%0d", k));
    end

    // reset after 7 inputs, then a full frame
    clear_a();
    feed_a(fr0, 0, -1, 7, 1'b0, ld);
    check("t4_pre_reset_out", qa_data.size(), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_rst_out_data",  $signed(out_data_a), 0);
    check("t4_rst_busy",      {31'd0, busy_a}, 0);
    #1 reset = 1'b0;
    clear_a();
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_stale", qa_data.size(), 0);
    feed_a(fr0, 0, -1, -1, 1'b0, ld);
    wait_done_a("t4", 20);
    model_pool(fr0, 4, 4, 2);
    compare_a("t4");
    if (qa_data.size() > 0) begin
      check("t4_first_data", qa_data[0], 5);
      check("t4_first_addr", qa_addr[0], 0);
    end

    // in_valid in IDLE, start with in_valid, start mid-RUN: all ignored
    clear_a();
    repeat (3) begin
      @(posedge clk); #1;
      in_valid_a = 1'b1;
      in_data_a  = 16'sh7fff;
    end
    feed_a(fr0, 0, 10, -1, 1'b1, ld);
    wait_done_a("t5", 20);
    compare_a("t5");

    // odd 5x5 map: last column and row dropped
    @(posedge clk); #1;
    start_b = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      start_b    = 1'b0;
      in_valid_b = 1'b1;
      in_data_b  = 16'(frb[i]);
      ld = cyc;
    end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    repeat (6) @(negedge clk);
    model_pool(frb, 5, 5, 1);
    check("t6_count", qb_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < qb_data.size(); i++) begin
      check($sformatf("t6_data%0d", i), qb_data[i], exp_data[i]);
      check($sformatf("t6_addr%0d", i), qb_addr[i], exp_addr[i]);
    end
    check("t6_done_pulses", done_b_cnt, 1);
    check("t6_done_cycle", done_b_cyc, ld + 2);
    check("t6_busy_after", {31'd0, busy_b}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
